decode_stage: RTL and testbench

Registered decode stage for the pipelined RISC-V core, replacing the single-cycle control-unit/sign-extender pair.
- Decodes one 32-bit instruction per cycle and generates all control fields, the register indices and an XLEN-wide immediate.
- Captures the result into an ID/EX pipeline register with valid/stall/flush handling.
- Branch resolution moves to EX, so the stage emits branch/jump type instead of PCSrc.

---
 rtl/decode_stage.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_stage: RISC-V instruction decode with ID/EX pipeline register      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             cnt_clr_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic             reg_write_o,
  output logic             alu_src_o,
  output logic             alu_src_a_o,
  output logic             mem_write_o,
  output logic [1:0]       result_src_o,
  output logic [3:0]       alu_control_o,
  output logic [2:0]       data_control_o,
  output logic             branch_o,
  output logic [2:0]       br_funct3_o,
  output logic [1:0]       jump_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_I      = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] C_IMM_I = 3'b000;
  localparam logic [2:0] C_IMM_S = 3'b001;
  localparam logic [2:0] C_IMM_B = 3'b010;
  localparam logic [2:0] C_IMM_U = 3'b011;
  localparam logic [2:0] C_IMM_J = 3'b100;

  localparam logic [3:0] C_ALU_ADD  = 4'b0000;
  localparam logic [3:0] C_ALU_SUB  = 4'b0001;
  localparam logic [3:0] C_ALU_AND  = 4'b0010;
  localparam logic [3:0] C_ALU_OR   = 4'b0011;
  localparam logic [3:0] C_ALU_XOR  = 4'b0100;
  localparam logic [3:0] C_ALU_SLT  = 4'b0101;
  localparam logic [3:0] C_ALU_SLTU = 4'b0110;
  localparam logic [3:0] C_ALU_SLL  = 4'b0111;
  localparam logic [3:0] C_ALU_SRL  = 4'b1000;
  localparam logic [3:0] C_ALU_SRA  = 4'b1001;
  localparam logic [3:0] C_ALU_PASSB = 4'b1010;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_alt;
  logic [3:0]      w_alu_arith;
  logic            w_reg_write;
  logic            w_alu_src;
  logic            w_alu_src_a;
  logic            w_mem_write;
  logic [1:0]      w_result_src;
  logic [3:0]      w_alu_ctrl;
  logic [2:0]      w_data_ctrl;
  logic            w_branch;
  logic [2:0]      w_br_funct3;
  logic [1:0]      w_jump;
  logic [2:0]      w_imm_src;
  logic            w_illegal;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_capture;
  logic            w_bubble;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic             r_alu_src;
  logic             r_alu_src_a;
  logic             r_mem_write;
  logic [1:0]       r_result_src;
  logic [3:0]       r_alu_ctrl;
  logic [2:0]       r_data_ctrl;
  logic             r_branch;
  logic [2:0]       r_br_funct3;
  logic [1:0]       r_jump;
  logic [XLEN-1:0]  r_imm;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_alt    = instr_i[30];

  // Shared arithmetic decode for R and I-ALU; funct7 only selects SUB on R-type
  always_comb begin
    w_alu_arith = C_ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_arith = (w_alt && (w_opcode == C_OP_R)) ? C_ALU_SUB : C_ALU_ADD;
      3'b001:  w_alu_arith = C_ALU_SLL;
      3'b010:  w_alu_arith = C_ALU_SLT;
      3'b011:  w_alu_arith = C_ALU_SLTU;
      3'b100:  w_alu_arith = C_ALU_XOR;
      3'b101:  w_alu_arith = w_alt ? C_ALU_SRA : C_ALU_SRL;
      3'b110:  w_alu_arith = C_ALU_OR;
      default: w_alu_arith = C_ALU_AND;
    endcase
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_ctrl   = C_ALU_ADD;
    w_data_ctrl  = 3'b000;
    w_branch     = 1'b0;
    w_br_funct3  = 3'b000;
    w_jump       = 2'b00;
    w_imm_src    = C_IMM_I;
    w_illegal    = 1'b0;
    case (w_opcode)
      C_OP_R: begin
        w_reg_write = 1'b1;
        w_alu_ctrl  = w_alu_arith;
      end
      C_OP_I: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = w_alu_arith;
      end
      C_OP_LOAD: begin
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
          w_illegal = 1'b1;
        end else begin
          w_reg_write  = 1'b1;
          w_alu_src    = 1'b1;
          w_result_src = 2'b01;
          w_data_ctrl  = w_funct3;
        end
      end
      C_OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_src   = C_IMM_S;
        w_data_ctrl = w_funct3;
      end
      C_OP_BRANCH: begin
        w_branch    = 1'b1;
        w_alu_ctrl  = C_ALU_SUB;
        w_imm_src   = C_IMM_B;
        w_br_funct3 = w_funct3;
      end
      C_OP_JAL: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_alu_src_a  = 1'b1;
        w_result_src = 2'b10;
        w_jump       = 2'b01;
        w_imm_src    = C_IMM_J;
      end
      C_OP_JALR: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 2'b10;
        w_jump       = 2'b10;
      end
      C_OP_LUI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = C_ALU_PASSB;
        w_imm_src   = C_IMM_U;
      end
      C_OP_AUIPC: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_src_a = 1'b1;
        w_imm_src   = C_IMM_U;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
    case (w_imm_src)
      C_IMM_S: w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      C_IMM_B: w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      C_IMM_U: w_imm32 = {instr_i[31:12], 12'b0};
      C_IMM_J: w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
      default: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
    endcase
  end

  // Fill the whole word with the sign first so XLEN=32 needs no zero-width replication
  always_comb begin
    w_imm       = {XLEN{w_imm32[31]}};
    w_imm[31:0] = w_imm32;
  end

  assign w_capture = !flush_i && !stall_i;
  assign w_bubble  = flush_i || (!stall_i && !valid_i);

  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_alu_ctrl   <= 4'b0000;
      r_data_ctrl  <= 3'b000;
      r_branch     <= 1'b0;
      r_br_funct3  <= 3'b000;
      r_jump       <= 2'b00;
      r_imm        <= '0;
      r_illegal    <= 1'b0;
    end else if (w_capture) begin
      r_valid      <= 1'b1;
      r_pc         <= pc_i;
      r_rs1        <= instr_i[19:15];
      r_rs2        <= instr_i[24:20];
      r_rd         <= instr_i[11:7];
      r_reg_write  <= w_reg_write;
      r_alu_src    <= w_alu_src;
      r_alu_src_a  <= w_alu_src_a;
      r_mem_write  <= w_mem_write;
      r_result_src <= w_result_src;
      r_alu_ctrl   <= w_alu_ctrl;
      r_data_ctrl  <= w_data_ctrl;
      r_branch     <= w_branch;
      r_br_funct3  <= w_br_funct3;
      r_jump       <= w_jump;
      r_imm        <= w_imm;
      r_illegal    <= w_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_cnt <= '0;
    end else if (w_capture && valid_i && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign valid_o        = r_valid;
  assign pc_o           = r_pc;
  assign rs1_o          = r_rs1;
  assign rs2_o          = r_rs2;
  assign rd_o           = r_rd;
  assign reg_write_o    = r_reg_write;
  assign alu_src_o      = r_alu_src;
  assign alu_src_a_o    = r_alu_src_a;
  assign mem_write_o    = r_mem_write;
  assign result_src_o   = r_result_src;
  assign alu_control_o  = r_alu_ctrl;
  assign data_control_o = r_data_ctrl;
  assign branch_o       = r_branch;
  assign br_funct3_o    = r_br_funct3;
  assign jump_o         = r_jump;
  assign imm_o          = r_imm;
  assign illegal_o      = r_illegal;
  assign instr_count_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_stage: directed self-checking bench for decode_stage           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic [31:0]      instr_i;
  logic [XLEN-1:0]  pc_i;
  logic             stall_i;
  logic             flush_i;
  logic             cnt_clr_i;
  logic             valid_o;
  logic [XLEN-1:0]  pc_o;
  logic [4:0]       rs1_o;
  logic [4:0]       rs2_o;
  logic [4:0]       rd_o;
  logic             reg_write_o;
  logic             alu_src_o;
  logic             alu_src_a_o;
  logic             mem_write_o;
  logic [1:0]       result_src_o;
  logic [3:0]       alu_control_o;
  logic [2:0]       data_control_o;
  logic             branch_o;
  logic [2:0]       br_funct3_o;
  logic [1:0]       jump_o;
  logic [XLEN-1:0]  imm_o;
  logic             illegal_o;
  logic [CNT_W-1:0] instr_count_o;

  int checks;
  int fails;
  logic [CNT_W-1:0] exp_cnt;

  localparam logic [31:0] ADDI  = 32'hFFF00093;
  localparam logic [31:0] LUI   = 32'h123452B7;
  localparam logic [31:0] SW    = 32'h0020A423;
  localparam logic [31:0] JAL   = 32'hFFDFF0EF;
  localparam logic [31:0] BNE   = 32'h00209463;
  localparam logic [31:0] SUB   = 32'h402081B3;
  localparam logic [31:0] SRAI  = 32'h4030D213;
  localparam logic [31:0] LD    = 32'h00003083;
  localparam logic [31:0] ILLOP = 32'h0000007F;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
    .valid_o(valid_o), .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .alu_src_o(alu_src_o), .alu_src_a_o(alu_src_a_o),
    .mem_write_o(mem_write_o), .result_src_o(result_src_o),
    .alu_control_o(alu_control_o), .data_control_o(data_control_o),
    .branch_o(branch_o), .br_funct3_o(br_funct3_o), .jump_o(jump_o),
    .imm_o(imm_o), .illegal_o(illegal_o), .instr_count_o(instr_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, cross one rising edge, and return 1 ns later for sampling
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl, input logic clr);
    valid_i   = v;
    instr_i   = ins;
    pc_i      = pc;
    stall_i   = st;
    flush_i   = fl;
    cnt_clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic bump;
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cycle(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_cnt = '0;
    checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0h expected 0", valid_o); end
    checks++; if (reg_write_o !== 1'b0) begin fails++; $display("FAIL reset_reg_write: got %0h expected 0", reg_write_o); end
    checks++; if (alu_src_o !== 1'b0) begin fails++; $display("FAIL reset_alu_src: got %0h expected 0", alu_src_o); end
    checks++; if (imm_o !== 32'h0) begin fails++; $display("FAIL reset_imm: got %0h expected 0", imm_o); end
    checks++; if (rd_o !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0h expected 0", rd_o); end
    checks++; if (instr_count_o !== 4'h0) begin fails++; $display("FAIL reset_count: got %0h expected 0", instr_count_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi;
    cycle(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (valid_o !== 1'b1) begin fails++; $display("FAIL addi_valid: got %0h expected 1", valid_o); end
    checks++; if (rd_o !== 5'd1) begin fails++; $display("FAIL addi_rd: got %0h expected 1", rd_o); end
    checks++; if (reg_write_o !== 1'b1) begin fails++; $display("FAIL addi_reg_write: got %0h expected 1", reg_write_o); end
    checks++; if (alu_src_o !== 1'b1) begin fails++; $display("FAIL addi_alu_src: got %0h expected 1", alu_src_o); end
    checks++; if (alu_control_o !== 4'b0000) begin fails++; $display("FAIL addi_alu: got %0h expected 0", alu_control_o); end
    checks++; if (imm_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm: got %0h expected ffffffff", imm_o); end
    checks++; if (instr_count_o !== 4'd1) begin fails++; $display("FAIL addi_count: got %0h expected 1", instr_count_o); end
  endtask

  task automatic test_opcodes;
    cycle(1'b1, LUI, 32'h4, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (imm_o !== 32'h12345000) begin fails++; $display("FAIL lui_imm: got %0h expected 12345000", imm_o); end
    checks++; if (alu_control_o !== 4'b1010) begin fails++; $display("FAIL lui_alu: got %0h expected a", alu_control_o); end
    checks++; if (rd_o !== 5'd5) begin fails++; $display("FAIL lui_rd: got %0h expected 5", rd_o); end

    cycle(1'b1, SW, 32'h8, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (mem_write_o !== 1'b1) begin fails++; $display("FAIL sw_mem_write: got %0h expected 1", mem_write_o); end
    checks++; if (reg_write_o !== 1'b0) begin fails++; $display("FAIL sw_reg_write: got %0h expected 0", reg_write_o); end
    checks++; if (imm_o !== 32'h8) begin fails++; $display("FAIL sw_imm: got %0h expected 8", imm_o); end
    checks++; if (data_control_o !== 3'b010) begin fails++; $display("FAIL sw_data_ctrl: got %0h expected 2", data_control_o); end
    checks++; if (rs1_o !== 5'd1 || rs2_o !== 5'd2) begin fails++; $display("FAIL sw_rs: got %0h/%0h expected 1/2", rs1_o, rs2_o); end

    cycle(1'b1, JAL, 32'h100, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (jump_o !== 2'b01) begin fails++; $display("FAIL jal_jump: got %0h expected 1", jump_o); end
    checks++; if (imm_o !== 32'hFFFFFFFC) begin fails++; $display("FAIL jal_imm: got %0h expected fffffffc", imm_o); end
    checks++; if (result_src_o !== 2'b10) begin fails++; $display("FAIL jal_result_src: got %0h expected 2", result_src_o); end
    checks++; if (pc_o !== 32'h100) begin fails++; $display("FAIL jal_pc: got %0h expected 100", pc_o); end
    checks++; if (alu_src_a_o !== 1'b1) begin fails++; $display("FAIL jal_alu_src_a: got %0h expected 1", alu_src_a_o); end

    cycle(1'b1, BNE, 32'h10, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (branch_o !== 1'b1 || br_funct3_o !== 3'b001) begin fails++; $display("FAIL bne_branch: got %0h/%0h expected 1/1", branch_o, br_funct3_o); end
    checks++; if (alu_control_o !== 4'b0001) begin fails++; $display("FAIL bne_alu: got %0h expected 1", alu_control_o); end
    checks++; if (imm_o !== 32'h8) begin fails++; $display("FAIL bne_imm: got %0h expected 8", imm_o); end
    checks++; if (reg_write_o !== 1'b0) begin fails++; $display("FAIL bne_reg_write: got %0h expected 0", reg_write_o); end

    cycle(1'b1, SUB, 32'h14, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (alu_control_o !== 4'b0001 || alu_src_o !== 1'b0) begin fails++; $display("FAIL sub_alu: got %0h/%0h expected 1/0", alu_control_o, alu_src_o); end

    cycle(1'b1, SRAI, 32'h18, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (alu_control_o !== 4'b1001) begin fails++; $display("FAIL srai_alu: got %0h expected 9", alu_control_o); end

    cycle(1'b1, LD, 32'h1C, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (illegal_o !== 1'b1 || reg_write_o !== 1'b0) begin fails++; $display("FAIL ld_illegal: got %0h/%0h expected 1/0", illegal_o, reg_write_o); end
    checks++; if (instr_count_o !== exp_cnt) begin fails++; $display("FAIL opcodes_count: got %0h expected %0h", instr_count_o, exp_cnt); end
  endtask

  task automatic test_stall;
    cycle(1'b1, ADDI, 32'h20, 1'b0, 1'b0, 1'b0); bump();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, LUI, 32'h24, 1'b1, 1'b0, 1'b0);
      checks++; if (imm_o !== 32'hFFFFFFFF || alu_control_o !== 4'b0000 || rd_o !== 5'd1) begin
        fails++; $display("FAIL stall_hold[%0d]: got imm %0h alu %0h rd %0h expected ffffffff 0 1", i, imm_o, alu_control_o, rd_o);
      end
      checks++; if (instr_count_o !== exp_cnt) begin fails++; $display("FAIL stall_count[%0d]: got %0h expected %0h", i, instr_count_o, exp_cnt); end
    end
    cycle(1'b1, LUI, 32'h24, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (imm_o !== 32'h12345000 || pc_o !== 32'h24) begin fails++; $display("FAIL stall_release: got imm %0h pc %0h expected 12345000 24", imm_o, pc_o); end
  endtask

  task automatic test_flush_bubble;
    cycle(1'b1, ADDI, 32'h28, 1'b1, 1'b1, 1'b0);
    checks++; if (valid_o !== 1'b0 || reg_write_o !== 1'b0) begin fails++; $display("FAIL flush_stall: got valid %0h rw %0h expected 0 0", valid_o, reg_write_o); end
    checks++; if (instr_count_o !== exp_cnt) begin fails++; $display("FAIL flush_count: got %0h expected %0h", instr_count_o, exp_cnt); end
    cycle(1'b1, SW, 32'h2C, 1'b0, 1'b0, 1'b0); bump();
    cycle(1'b0, SW, 32'h30, 1'b0, 1'b0, 1'b0);
    checks++; if (valid_o !== 1'b0 || mem_write_o !== 1'b0) begin fails++; $display("FAIL bubble_capture: got valid %0h mw %0h expected 0 0", valid_o, mem_write_o); end
    checks++; if (instr_count_o !== exp_cnt) begin fails++; $display("FAIL bubble_count: got %0h expected %0h", instr_count_o, exp_cnt); end
  endtask

  task automatic test_illegal;
    cycle(1'b1, ILLOP, 32'h34, 1'b0, 1'b0, 1'b0); bump();
    checks++; if (illegal_o !== 1'b1 || valid_o !== 1'b1) begin fails++; $display("FAIL illegal_flag: got ill %0h valid %0h expected 1 1", illegal_o, valid_o); end
    checks++; if ({reg_write_o, mem_write_o, branch_o, jump_o} !== 5'b0) begin
      fails++; $display("FAIL illegal_enables: got %0h expected 0", {reg_write_o, mem_write_o, branch_o, jump_o});
    end
    checks++; if (instr_count_o !== exp_cnt) begin fails++; $display("FAIL illegal_count: got %0h expected %0h", instr_count_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall;
    cycle(1'b1, ADDI, 32'h38, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, ADDI, 32'h38, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_cnt = '0;
    checks++; if (valid_o !== 1'b0 || reg_write_o !== 1'b0 || instr_count_o !== 4'h0) begin
      fails++; $display("FAIL reset_mid_stall: got valid %0h rw %0h cnt %0h expected 0 0 0", valid_o, reg_write_o, instr_count_o);
    end
  endtask

  task automatic test_counter;
    cycle(1'b0, ADDI, 32'h0, 1'b0, 1'b0, 1'b1);
    exp_cnt = '0;
    checks++; if (instr_count_o !== 4'h0) begin fails++; $display("FAIL cnt_clear: got %0h expected 0", instr_count_o); end
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, ADDI, 32'h40, 1'b0, 1'b0, 1'b0);
      if (i == 14 || i == 16) begin
        checks++; if (instr_count_o !== 4'hF) begin fails++; $display("FAIL cnt_saturate[%0d]: got %0h expected f", i, instr_count_o); end
      end
    end
    cycle(1'b1, LUI, 32'h44, 1'b0, 1'b0, 1'b1);
    checks++; if (instr_count_o !== 4'h0 || valid_o !== 1'b1) begin
      fails++; $display("FAIL cnt_clr_priority: got cnt %0h valid %0h expected 0 1", instr_count_o, valid_o);
    end
    cycle(1'b1, LUI, 32'h48, 1'b0, 1'b0, 1'b0);
    checks++; if (instr_count_o !== 4'h1) begin fails++; $display("FAIL cnt_after_clr: got %0h expected 1", instr_count_o); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    exp_cnt = '0;
    rst_n = 1'b0; valid_i = 1'b0; instr_i = '0; pc_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
    test_reset();
    test_addi();
    test_opcodes();
    test_stall();
    test_flush_bubble();
    test_illegal();
    test_reset_mid_stall();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
